regfile_scoreboard: RTL and testbench

//   Parametrised integer register file for the rv32i core: 2 combinational read ports,
//   1 write port, hardwired-zero x0, write-to-read bypass.

---
 rtl/regfile_scoreboard.sv | 99 +++++++++
 tb/tb_regfile_scoreboard.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : regfile_scoreboard                                                |
// | Integer register file (2R/1W, write bypass, optional hardwired x0) with a  |
// | pending-write scoreboard: RAW busy flags and WAW-gated issue handshake.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AW-1:0]                rd_addr1,
    output logic [XLEN-1:0]              rd_data1,
    output logic                         rs1_busy,
    input  logic [AW-1:0]                rd_addr2,
    output logic [XLEN-1:0]              rd_data2,
    output logic                         rs2_busy,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [XLEN-1:0]              wr_data,
    input  logic                         iss_valid,
    input  logic [AW-1:0]                iss_rd,
    output logic                         iss_ready,
    output logic [$clog2(NREGS+1)-1:0]   pend_cnt,
    output logic                         wb_err
);

    localparam int c_cnt_w    = $clog2(NREGS+1);
    localparam bit c_has_zero = (ZERO_REG != 0);

    logic [XLEN-1:0]    r_regs [NREGS];
    logic [NREGS-1:0]   r_pend;
    logic [c_cnt_w-1:0] r_pend_cnt;
    logic               r_wb_err;

    logic               w_wr_zero, w_wr_act;
    logic               w_rd1_zero, w_rd2_zero, w_iss_zero;
    logic               w_rd1_byp, w_rd2_byp;
    logic               w_iss_ready, w_iss_set;
    logic               w_cnt_inc, w_cnt_dec;
    logic [NREGS-1:0]   w_pend_nxt;

    always_comb begin
        w_wr_zero  = c_has_zero && (wr_addr  == '0);
        w_rd1_zero = c_has_zero && (rd_addr1 == '0);
        w_rd2_zero = c_has_zero && (rd_addr2 == '0);
        w_iss_zero = c_has_zero && (iss_rd   == '0);
        w_wr_act   = wr_en && !w_wr_zero;
        w_rd1_byp  = wr_en && (wr_addr == rd_addr1);
        w_rd2_byp  = wr_en && (wr_addr == rd_addr2);

        // A same-cycle writeback to the destination retires the old producer,
        // so the new issue may proceed.
        w_iss_ready = !r_pend[iss_rd] || (wr_en && (wr_addr == iss_rd)) || w_iss_zero;
        w_iss_set   = iss_valid && w_iss_ready && !w_iss_zero;

        w_pend_nxt = r_pend;
        if (w_wr_act)  w_pend_nxt[wr_addr] = 1'b0;
        if (w_iss_set) w_pend_nxt[iss_rd]  = 1'b1;

        w_cnt_inc = w_iss_set && !r_pend[iss_rd];
        w_cnt_dec = w_wr_act && r_pend[wr_addr] && !(w_iss_set && (iss_rd == wr_addr));
    end

    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        if (!w_rd1_zero) rd_data1 = w_rd1_byp ? wr_data : r_regs[rd_addr1];
        if (!w_rd2_zero) rd_data2 = w_rd2_byp ? wr_data : r_regs[rd_addr2];
        rs1_busy  = r_pend[rd_addr1] && !w_rd1_byp && !w_rd1_zero;
        rs2_busy  = r_pend[rd_addr2] && !w_rd2_byp && !w_rd2_zero;
        iss_ready = w_iss_ready;
        pend_cnt  = r_pend_cnt;
        wb_err    = r_wb_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_pend     <= '0;
            r_pend_cnt <= '0;
            r_wb_err   <= 1'b0;
        end else begin
            if (w_wr_act) r_regs[wr_addr] <= wr_data;
            r_pend <= w_pend_nxt;
            if (w_cnt_inc && !w_cnt_dec)
                r_pend_cnt <= r_pend_cnt + c_cnt_w'(1);
            else if (w_cnt_dec && !w_cnt_inc)
                r_pend_cnt <= r_pend_cnt - c_cnt_w'(1);
            if (w_wr_act && !r_pend[wr_addr]) r_wb_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_regfile_scoreboard                                             |
// | Directed self-checking bench for regfile_scoreboard (32x32 and 16x64 x0).  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0, iss_rd = '0;
    logic [31:0] wr_data = '0, rd_data1, rd_data2;
    logic        wr_en = 1'b0, iss_valid = 1'b0;
    logic        rs1_busy, rs2_busy, iss_ready, wb_err;
    logic [5:0]  pend_cnt;

    logic [3:0]  b_rd_addr1 = '0, b_rd_addr2 = '0, b_wr_addr = '0, b_iss_rd = '0;
    logic [63:0] b_wr_data = '0, b_rd_data1, b_rd_data2;
    logic        b_wr_en = 1'b0, b_iss_valid = 1'b0;
    logic        b_rs1_busy, b_rs2_busy, b_iss_ready, b_wb_err;
    logic [4:0]  b_pend_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_scoreboard u_dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rs1_busy(rs1_busy),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2), .rs2_busy(rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .pend_cnt(pend_cnt), .wb_err(wb_err)
    );

    regfile_scoreboard #(.XLEN(64), .NREGS(16), .AW(4), .ZERO_REG(0)) u_dut64 (
        .clk(clk), .rst(rst),
        .rd_addr1(b_rd_addr1), .rd_data1(b_rd_data1), .rs1_busy(b_rs1_busy),
        .rd_addr2(b_rd_addr2), .rd_data2(b_rd_data2), .rs2_busy(b_rs2_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .iss_valid(b_iss_valid), .iss_rd(b_iss_rd), .iss_ready(b_iss_ready),
        .pend_cnt(b_pend_cnt), .wb_err(b_wb_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        rd_addr1 = 5'd5; rd_addr2 = 5'd7; iss_rd = 5'd3;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_rd1",   rd_data1,  0);
        chk("rst_rd2",   rd_data2,  0);
        chk("rst_busy1", rs1_busy,  0);
        chk("rst_ready", iss_ready, 1);
        chk("rst_cnt",   pend_cnt,  0);
        chk("rst_err",   wb_err,    0);

        // issue x5 -> busy next cycle
        iss_valid = 1'b1; iss_rd = 5'd5;
        #1 chk("iss5_ready", iss_ready, 1);
        tick();
        iss_valid = 1'b0;
        #1;
        chk("iss5_cnt",  pend_cnt, 1);
        chk("iss5_busy", rs1_busy, 1);

        // WAW stall, then same-cycle writeback releases it
        iss_valid = 1'b1; iss_rd = 5'd5;
        #1 chk("waw_stall", iss_ready, 0);
        tick();
        #1 chk("waw_cnt", pend_cnt, 1);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        #1;
        chk("waw_wr_ready", iss_ready, 1);
        chk("byp_rd1",      rd_data1,  32'hDEADBEEF);
        chk("byp_busy1",    rs1_busy,  0);
        tick();
        wr_en = 1'b0; iss_valid = 1'b0;
        #1;
        chk("waw_keep_cnt",  pend_cnt, 1);
        chk("waw_keep_busy", rs1_busy, 1);
        chk("arr_rd1",       rd_data1, 32'hDEADBEEF);
        chk("waw_err",       wb_err,   0);

        // plain writeback retires x5
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678;
        #1 chk("wb5_byp", rd_data1, 32'h12345678);
        tick();
        wr_en = 1'b0;
        #1;
        chk("wb5_cnt",  pend_cnt, 0);
        chk("wb5_busy", rs1_busy, 0);
        chk("wb5_arr",  rd_data1, 32'h12345678);

        // x0 hardwired
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_rd = 5'd0; rd_addr2 = 5'd0;
        #1;
        chk("x0_ready", iss_ready, 1);
        chk("x0_byp",   rd_data2,  0);
        chk("x0_busy",  rs2_busy,  0);
        tick();
        wr_en = 1'b0; iss_valid = 1'b0;
        #1;
        chk("x0_rd",   rd_data2, 0);
        chk("x0_cnt",  pend_cnt, 0);
        chk("x0_err",  wb_err,   0);

        // writeback without producer
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAAAA5555; rd_addr2 = 5'd7;
        tick();
        wr_en = 1'b0;
        #1;
        chk("err_set", wb_err,   1);
        chk("err_arr", rd_data2, 32'hAAAA5555);
        tick();
        chk("err_sticky", wb_err, 1);

        // async reset mid-cycle
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        #1 chk("pre_rst_cnt", pend_cnt, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_rd1", rd_data1, 0);
        chk("arst_rd2", rd_data2, 0);
        chk("arst_cnt", pend_cnt, 0);
        chk("arst_err", wb_err,   0);
        rst = 1'b0;
        tick();

        // fill scoreboard
        for (int i = 1; i < 32; i++) begin
            iss_valid = 1'b1; iss_rd = 5'(i);
            tick();
        end
        iss_valid = 1'b0;
        #1 chk("full_cnt", pend_cnt, 31);
        iss_valid = 1'b1; iss_rd = 5'd31;
        #1 chk("full_stall", iss_ready, 0);
        tick();
        chk("full_stall_cnt", pend_cnt, 31);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h4; iss_rd = 5'd4;
        tick();
        chk("same_reg_cnt", pend_cnt, 31);
        iss_valid = 1'b0;
        tick();
        chk("dec_cnt", pend_cnt, 30);
        wr_addr = 5'd10; iss_valid = 1'b1; iss_rd = 5'd4;
        tick();
        wr_en = 1'b0; iss_valid = 1'b0;
        #1;
        chk("net0_cnt", pend_cnt, 30);
        chk("no_err",   wb_err,   0);

        // 64-bit, ordinary x0
        b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 64'h123456789ABCDEF0;
        b_rd_addr1 = 4'd0;
        #1 chk("x64_byp", b_rd_data1, 64'h123456789ABCDEF0);
        tick();
        b_wr_en = 1'b0;
        #1;
        chk("x64_arr", b_rd_data1, 64'h123456789ABCDEF0);
        chk("x64_err", b_wb_err,   1);
        b_iss_valid = 1'b1; b_iss_rd = 4'd0;
        tick();
        b_iss_valid = 1'b0;
        #1;
        chk("x64_cnt",  b_pend_cnt, 1);
        chk("x64_busy", b_rs1_busy, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
